// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ write-domain requesters.
// Optional saturating wFull stall counter: define FIFO_ARB_STALL_CNT_EN.
module fifo_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wFull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wData,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
`ifdef FIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [NREQ-1:0]    grant_reg, grant_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

  logic [NREQ-1:0]    rot_valid;
  logic [NREQ-1:0]    rot_pick;
  logic [2*NREQ-1:0]  dbl_pick;
  logic [NREQ-1:0]    pick_onehot;
  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   g_succ;
  logic               g_valid;
  logic               g_last;
  logic               last_beat;
  logic               xfer;
  logic               burst_end;
  logic [DSIZE-1:0]   masked_data [NREQ];
  logic [DSIZE-1:0]   wdata_or;

  // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot_valid   = NREQ'({req_valid, req_valid} >> rr_ptr_reg);
    rot_pick    = rot_valid & (-rot_valid);
    dbl_pick    = {{NREQ{1'b0}}, rot_pick} << rr_ptr_reg;
    pick_onehot = dbl_pick[NREQ-1:0] | dbl_pick[2*NREQ-1:NREQ];
  end

  always_comb begin
    g_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_reg[k]) g_idx = PTR_W'(k);
    end
    g_succ = (g_idx == PTR_W'(NREQ - 1)) ? '0 : g_idx + PTR_W'(1);
  end

  assign busy      = (state_reg == BURST);
  assign g_valid   = |(req_valid & grant_reg);
  assign g_last    = |(req_last & grant_reg);
  assign last_beat = (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
  assign xfer      = busy && g_valid && !wFull;
  // An absent beat ends the burst even while the FIFO is full.
  assign burst_end = busy && (!g_valid || (xfer && (g_last || last_beat)));

  assign winc      = xfer;
  assign req_ready = (busy && !wFull) ? grant_reg : '0;
  assign grant     = grant_reg;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign masked_data[gi] = req_data[gi*DSIZE +: DSIZE] & {DSIZE{grant_reg[gi]}};
    end
  endgenerate

  always_comb begin
    wdata_or = '0;
    for (int k = 0; k < NREQ; k++) begin
      wdata_or = wdata_or | masked_data[k];
    end
  end

  assign wData = wdata_or;

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) begin
          grant_next    = pick_onehot;
          beat_cnt_next = '0;
          state_next    = BURST;
        end
      end
      BURST: begin
        if (burst_end) begin
          state_next    = IDLE;
          grant_next    = '0;
          rr_ptr_next   = g_succ;
          beat_cnt_next = '0;
        end else if (xfer) begin
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      stall_cnt_reg <= '0;
    end else if (busy && g_valid && wFull && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

  // Structural invariants of the grant register and the write strobe.
  a_grant_onehot0 : assert property (@(posedge wclk) disable iff (!wrst) $onehot0(grant_reg));
  a_busy_granted  : assert property (@(posedge wclk) disable iff (!wrst) busy |-> (grant_reg != '0));
  a_no_full_write : assert property (@(posedge wclk) disable iff (!wrst) winc |-> !wFull);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, round-robin order, short bursts, stalls, drop-out, mid-burst reset.
module tb_fifo_write_arbiter;
  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wFull;
  logic                  winc;
  logic [DSIZE-1:0]      wData;
  logic [NREQ-1:0]       grant;
  logic                  busy;
`ifdef FIFO_ARB_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int winc_cnt     = 0;
  int idle_cnt     = 0;
  int burst_no     = 0;
  logic prev_busy  = 1'b0;

  fifo_write_arbiter #(
    .NREQ      (NREQ),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wFull     (wFull),
    .winc      (winc),
    .wData     (wData),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with every requester valid
    wrst      = 1'b1;
    wFull     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b0000;
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    #2 wrst = 1'b0;
    tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_winc", winc, 1'b0);
    check("rst_wdata", wData, 8'h00);
    check("rst_ready", req_ready, 4'b0000);
`ifdef FIFO_ARB_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 16'd0);
`endif
    wrst = 1'b1;
    #1;
    check("idle_no_grant", grant, 4'b0000);
    tick();
    check("first_grant", grant, 4'b0001);
    check("first_wdata", wData, 8'h11);
    check("first_ready", req_ready, 4'b0001);
    for (int b = 0; b < MAX_BURST; b++) begin
      check($sformatf("r0_beat%0d_winc", b), winc, 1'b1);
      if (b < MAX_BURST - 1) tick();
    end
    tick();
    check("r0_end_busy", busy, 1'b0);
    check("r0_end_winc", winc, 1'b0);
    tick();
    check("second_grant", grant, 4'b0010);

    // Continuous requests from all four, 40 cycles from a fresh reset
    wrst = 1'b0;
    tick();
    wrst = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (winc) winc_cnt++;
      if (!busy) idle_cnt++;
      if (busy && !prev_busy) begin
        check($sformatf("rr_order%0d", burst_no), grant, 32'(1 << (burst_no % 4)));
        burst_no++;
      end
      prev_busy = busy;
    end
    check("rr_winc_cycles", winc_cnt, 32);
    check("rr_bubbles", idle_cnt, 8);
    check("rr_bursts", burst_no, 8);

    // Requester 2 alone, two beats with req_last on the second
    req_valid = 4'b0100;
    req_data[2*DSIZE +: DSIZE] = 8'hA5;
    tick();
    check("r2_grant", grant, 4'b0100);
    check("r2_beat0_winc", winc, 1'b1);
    check("r2_beat0_wdata", wData, 8'hA5);
    tick();
    req_data[2*DSIZE +: DSIZE] = 8'h5A;
    req_last = 4'b0100;
    #1;
    check("r2_beat1_winc", winc, 1'b1);
    check("r2_beat1_wdata", wData, 8'h5A);
    tick();
    check("r2_end_busy", busy, 1'b0);
    check("r2_end_winc", winc, 1'b0);
    req_valid = 4'b1111;
    req_last  = 4'b0000;
    tick();
    check("rr_ptr_after_r2", grant, 4'b1000);

    // wFull stall for 5 cycles after the first beat
    check("stall_beat0_winc", winc, 1'b1);
    tick();
    wFull = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("stall%0d_winc", s), winc, 1'b0);
      check($sformatf("stall%0d_ready", s), req_ready, 4'b0000);
      check($sformatf("stall%0d_grant", s), grant, 4'b1000);
      tick();
    end
    wFull = 1'b0;
    #1;
    for (int b = 1; b < MAX_BURST; b++) begin
      check($sformatf("post_stall_beat%0d_winc", b), winc, 1'b1);
      tick();
    end
    check("post_stall_end_busy", busy, 1'b0);
`ifdef FIFO_ARB_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 16'd5);
`endif

    // Granted requester drops req_valid after one beat
    tick();
    check("drop_grant", grant, 4'b0001);
    check("drop_beat0_winc", winc, 1'b1);
    tick();
    req_valid = 4'b1110;
    #1;
    check("drop_no_winc", winc, 1'b0);
    check("drop_still_busy", busy, 1'b1);
    tick();
    check("drop_idle_busy", busy, 1'b0);
    check("drop_idle_grant", grant, 4'b0000);
    tick();
    check("drop_next_grant", grant, 4'b0010);

    // Asynchronous reset during beat 2
    tick();
    check("arst_beat1_winc", winc, 1'b1);
    #2 wrst = 1'b0;
    #1;
    check("arst_winc", winc, 1'b0);
    check("arst_grant", grant, 4'b0000);
    check("arst_busy", busy, 1'b0);
    tick();
    check("arst_held_winc", winc, 1'b0);
    req_valid = 4'b1111;
    wrst = 1'b1;
    tick();
    check("arst_restart_grant", grant, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
